tier_link_rx: RTL and testbench

Receive end of the serialized inter-tier (TSV) link between adjacent stacked dies. It accepts narrow beats from the matching tier_link_tx on the neighbouring tier, reassembles WIDTH-bit words, and checks column parity. Good words go into a small elastic buffer with a valid/ready output. Consumed slots are returned to the transmitter as credits, so the TSV count per crossing signal group drops from WIDTH to LANES+2 (+2 credit return).

---
 rtl/tier_link_pkg.sv | 23 ++
 rtl/tier_link_rx_fifo.sv | 54 +++++
 rtl/tier_link_rx.sv | 109 ++++++++++
 tb/tb_tier_link_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tier_link_pkg.sv
// Shared definitions for the inter-tier TSV link: frame format, rx states and parity helper.
package tier_link_pkg;

  localparam int unsigned MAX_LANES = 64;
  localparam int unsigned CREDIT_W  = 2;

  typedef enum logic [1:0] {IDLE, DATA, PAR} rx_state_e;

  function automatic int unsigned frame_nbeats(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

  function automatic int unsigned beat_cnt_w(input int unsigned nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

  // Column parity accumulates one beat at a time; callers zero-extend to MAX_LANES.
  function automatic logic [MAX_LANES-1:0] col_parity_step(input logic [MAX_LANES-1:0] acc,
                                                           input logic [MAX_LANES-1:0] beat);
    return acc ^ beat;
  endfunction

endpackage

// File: rtl/tier_link_rx_fifo.sv
// Show-ahead receive buffer; a pop frees its slot for a push in the same cycle.
module tier_link_rx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CNTW-1:0]  cnt;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    empty   = (cnt == '0);
    full    = (cnt == CNTW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rp];
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      end
      if (do_pop) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/tier_link_rx.sv
// Receive end of the TSV link: reassembles beats into words, checks column parity,
// buffers good words and returns consumed slots to the transmitter as credits.
module tier_link_rx
  import tier_link_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                tsv_vld_IN,
  input  logic                tsv_sof_IN,
  input  logic [LANES-1:0]    tsv_data_IN,
  output logic                out_vld_OUT,
  output logic [WIDTH-1:0]    out_data_OUT,
  input  logic                out_rdy_IN,
  output logic [CREDIT_W-1:0] credit_rtn_OUT,
  output logic                par_err_OUT,
  output logic                sof_err_OUT,
  output logic                ovf_err_OUT
);

  localparam int unsigned NBEATS = frame_nbeats(WIDTH, LANES);
  localparam int unsigned CW     = beat_cnt_w(NBEATS);

  rx_state_e        state;
  logic [CW-1:0]    cnt;
  logic [LANES-1:0] par;
  logic [LANES-1:0] par_acc;
  logic [WIDTH-1:0] asm_word;
  logic             par_beat;
  logic             push;
  logic             par_bad;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  always_comb begin
    par_beat    = tsv_vld_IN && !tsv_sof_IN && (state == PAR);
    push        = par_beat && (tsv_data_IN == par);
    par_bad     = par_beat && (tsv_data_IN != par);
    out_vld_OUT = !fifo_empty;
    pop         = out_vld_OUT && out_rdy_IN;
    par_acc     = LANES'(col_parity_step(MAX_LANES'(par), MAX_LANES'(tsv_data_IN)));
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      par            <= '0;
      asm_word       <= '0;
      credit_rtn_OUT <= '0;
      par_err_OUT    <= 1'b0;
      sof_err_OUT    <= 1'b0;
      ovf_err_OUT    <= 1'b0;
    end else begin
      par_err_OUT    <= par_bad;
      sof_err_OUT    <= 1'b0;
      credit_rtn_OUT <= CREDIT_W'(pop) + CREDIT_W'(par_bad);
      if (push && fifo_full && !pop) ovf_err_OUT <= 1'b1;

      if (tsv_vld_IN) begin
        // SOF always restarts assembly; an aborted partial frame keeps its credit at the tx.
        if (tsv_sof_IN) begin
          if (state != IDLE) sof_err_OUT <= 1'b1;
          asm_word[LANES-1:0] <= tsv_data_IN;
          par                 <= tsv_data_IN;
          cnt                 <= CW'(1);
          state               <= (NBEATS == 1) ? PAR : DATA;
        end else begin
          case (state)
            DATA: begin
              asm_word[cnt*LANES +: LANES] <= tsv_data_IN;
              par                          <= par_acc;
              if (cnt == CW'(NBEATS - 1)) begin
                cnt   <= '0;
                state <= PAR;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            PAR: begin
              cnt   <= '0;
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  tier_link_rx_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk1 (clk1),
    .rst  (rst),
    .push (push),
    .din  (asm_word),
    .pop  (pop),
    .dout (out_data_OUT),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_tier_link_rx.sv
// Directed and randomized check of tier_link_rx against a queue-based frame model.
module tb_tier_link_rx;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned LANES  = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned NBEATS = WIDTH / LANES;

  logic             clk1 = 1'b0;
  logic             rst  = 1'b1;
  logic             vld  = 1'b0;
  logic             sof  = 1'b0;
  logic [7:0]       data = '0;
  logic             rdy  = 1'b0;
  logic             out_vld;
  logic [31:0]      out_data;
  logic [1:0]       credit;
  logic             par_err;
  logic             sof_err;
  logic             ovf_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] mq[$];
  logic [7:0]  mbeats[$];
  bit          mact;
  bit          m_perr;
  bit          m_serr;
  bit          m_ovf;
  int          m_cred;

  always #5 clk1 = ~clk1;

  tier_link_rx #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .DEPTH(DEPTH)
  ) dut (
    .clk1          (clk1),
    .rst           (rst),
    .tsv_vld_IN    (vld),
    .tsv_sof_IN    (sof),
    .tsv_data_IN   (data),
    .out_vld_OUT   (out_vld),
    .out_data_OUT  (out_data),
    .out_rdy_IN    (rdy),
    .credit_rtn_OUT(credit),
    .par_err_OUT   (par_err),
    .sof_err_OUT   (sof_err),
    .ovf_err_OUT   (ovf_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mbeats.delete();
    mact   = 0;
    m_perr = 0;
    m_serr = 0;
    m_ovf  = 0;
    m_cred = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; sof = 1'b0; rdy = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_credit", 64'(credit), 64'd0);
    chk("rst_errs", {61'd0, par_err, sof_err, ovf_err}, 64'd0);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock with the given inputs; model predicts the post-edge outputs.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d, input logic r);
    bit          pop;
    bit          push;
    bit          perr;
    logic [31:0] w;
    logic [7:0]  p;
    vld = v; sof = s; data = d; rdy = r;
    pop = (mq.size() > 0) && r;
    push = 0; perr = 0; m_serr = 0; w = '0; p = '0;
    if (v) begin
      if (s) begin
        if (mact) m_serr = 1;
        mbeats.delete();
        mbeats.push_back(d);
        mact = 1;
      end else if (mact) begin
        if (mbeats.size() < NBEATS) mbeats.push_back(d);
        else begin
          foreach (mbeats[i]) begin
            w = w + (32'(mbeats[i]) << (8 * i));
            p = p ^ mbeats[i];
          end
          if (p == d) push = 1; else perr = 1;
          mact = 0;
          mbeats.delete();
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else m_ovf = 1;
    end
    m_perr = perr;
    m_cred = int'(pop) + int'(perr);
    @(posedge clk1);
    #1;
    chk("out_vld", 64'(out_vld), 64'(mq.size() > 0));
    if (mq.size() > 0) chk("out_data", 64'(out_data), 64'(mq[0]));
    chk("credit", 64'(credit), 64'(m_cred));
    chk("par_err", 64'(par_err), 64'(m_perr));
    chk("sof_err", 64'(sof_err), 64'(m_serr));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    vld = 1'b0; sof = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic r,
                           input logic r_last, input logic [7:0] par_flip);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (i > 0) repeat (gap) cyc(1'b0, 1'b0, 8'h5A, r);
      cyc(1'b1, i == 0, w[8*i +: 8], r);
      p = p ^ w[8*i +: 8];
    end
    repeat (gap) cyc(1'b0, 1'b0, 8'h5A, r);
    cyc(1'b1, 1'b0, p ^ par_flip, r_last);
  endtask

  function automatic logic rnd_rdy();
    return $urandom_range(0, 3) != 0;
  endfunction

  initial begin
    model_clear();
    do_reset();

    // Clean frame, then pop.
    send_word(32'hA5A51234, 0, 1'b0, 1'b0, 8'h00);
    chk("clean_vld", 64'(out_vld), 64'd1);
    chk("clean_data", 64'(out_data), 64'hA5A51234);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clean_credit", 64'(credit), 64'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Gapped frame.
    send_word(32'hA5A51234, 3, 1'b0, 1'b0, 8'h00);
    chk("gap_data", 64'(out_data), 64'hA5A51234);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Parity error: 0x27 instead of 0x26.
    send_word(32'hA5A51234, 0, 1'b0, 1'b0, 8'h01);
    chk("perr_pulse", 64'(par_err), 64'd1);
    chk("perr_credit", 64'(credit), 64'd1);
    chk("perr_novld", 64'(out_vld), 64'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Early SOF after two beats, then a clean frame for 1.
    cyc(1'b1, 1'b1, 8'h34, 1'b0);
    cyc(1'b1, 1'b0, 8'h12, 1'b0);
    cyc(1'b1, 1'b1, 8'h01, 1'b0);
    chk("sof_pulse", 64'(sof_err), 64'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h01, 1'b0);
    chk("sof_data", 64'(out_data), 64'h00000001);
    chk("sof_credit", 64'(credit), 64'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Backpressure: two held in order, third overflows and sticks.
    send_word(32'h11223344, 0, 1'b0, 1'b0, 8'h00);
    send_word(32'h01020304, 1, 1'b0, 1'b0, 8'h00);
    send_word(32'hDEADBEEF, 0, 1'b0, 1'b0, 8'h00);
    chk("ovf_set", 64'(ovf_err), 64'd1);
    chk("ovf_head", 64'(out_data), 64'h11223344);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("order_second", 64'(out_data), 64'h01020304);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);

    // Full with a pop in the push cycle: no overflow.
    do_reset();
    send_word(32'h11223344, 0, 1'b0, 1'b0, 8'h00);
    send_word(32'h01020304, 0, 1'b0, 1'b0, 8'h00);
    send_word(32'hCAFEF00D, 0, 1'b0, 1'b1, 8'h00);
    chk("full_pop_noovf", 64'(ovf_err), 64'd0);
    chk("full_pop_credit", 64'(credit), 64'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("full_pop_order", 64'(out_data), 64'hCAFEF00D);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Pop and parity error together: two credits.
    send_word(32'h0BADF00D, 0, 1'b0, 1'b0, 8'h00);
    send_word(32'h12345678, 0, 1'b0, 1'b1, 8'h80);
    chk("dbl_credit", 64'(credit), 64'd2);

    // Reset mid-frame, then a clean frame.
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    cyc(1'b1, 1'b0, 8'h66, 1'b0);
    do_reset();
    send_word(32'hA5A51234, 0, 1'b0, 1'b0, 8'h00);
    chk("post_rst_data", 64'(out_data), 64'hA5A51234);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized frames with gaps, backpressure, corruption and aborts.
    for (int f = 0; f < 250; f++) begin
      logic [7:0] b[4];
      logic [7:0] p;
      int         kind;
      kind = $urandom_range(0, 19);
      p = '0;
      for (int i = 0; i < 4; i++) begin
        b[i] = 8'($urandom);
        p    = p ^ b[i];
      end
      if (kind == 2) cyc(1'b1, 1'b0, 8'($urandom), rnd_rdy());
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 8'($urandom), rnd_rdy());
        cyc(1'b1, i == 0, b[i], rnd_rdy());
        if (kind == 0 && i == 1) break;
      end
      if (kind != 0) begin
        if (kind == 1) p = p ^ 8'(1 << $urandom_range(0, 7));
        cyc(1'b1, 1'b0, p, rnd_rdy());
      end
    end
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
